// File: rtl/fetch_stage_controller_if.sv
// Hazard-control and IF/ID bundle between the hazard unit, imem,
// the decoder and the fetch stage controller.
interface fetch_stage_controller_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 9,
  parameter int CNT_WIDTH  = 16
);
  logic                  Stall;
  logic                  Flush;
  logic                  Block_PC_Write;
  logic                  Block_IF_ID_Write;
  logic [DATA_WIDTH-1:0] Branch_Target;
  logic [DATA_WIDTH-1:0] Instruction;
  logic [CTRL_WIDTH-1:0] ID_Control;
  logic [DATA_WIDTH-1:0] PC;
  logic [DATA_WIDTH-1:0] IF_ID_Instruction;
  logic [DATA_WIDTH-1:0] IF_ID_PC_Plus4;
  logic                  IF_ID_Valid;
  logic [CTRL_WIDTH-1:0] ID_EX_Control;
  logic [CNT_WIDTH-1:0]  Stall_Count;
  logic [CNT_WIDTH-1:0]  Flush_Count;

  modport master (
    output Stall, Flush, Block_PC_Write,
    output Block_IF_ID_Write, Branch_Target,
    output Instruction, ID_Control,
    input  PC, IF_ID_Instruction, IF_ID_PC_Plus4,
    input  IF_ID_Valid, ID_EX_Control,
    input  Stall_Count, Flush_Count
  );

  modport slave (
    input  Stall, Flush, Block_PC_Write,
    input  Block_IF_ID_Write, Branch_Target,
    input  Instruction, ID_Control,
    output PC, IF_ID_Instruction, IF_ID_PC_Plus4,
    output IF_ID_Valid, ID_EX_Control,
    output Stall_Count, Flush_Count
  );
endinterface

// File: rtl/fetch_stage_controller.sv
// Fetch stage: PC and IF/ID register under hazard-unit control,
// ID/EX control bubbling and saturating stall/flush counters.
module fetch_stage_controller #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    CTRL_WIDTH = 9,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000,
  parameter int                    CNT_WIDTH  = 16
) (
  input logic                     clk,
  input logic                     reset,
  fetch_stage_controller_if.slave bus
);

  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_ifid_instr;
  logic [DATA_WIDTH-1:0] r_ifid_pc4;
  logic                  r_ifid_valid;
  logic [CNT_WIDTH-1:0]  r_stall_cnt;
  logic [CNT_WIDTH-1:0]  r_flush_cnt;

  logic                  w_flush_acc;
  logic [DATA_WIDTH-1:0] w_pc_plus4;

  // A held PC wins over a branch redirect; the branch retries later.
  assign w_flush_acc = bus.Flush & ~bus.Block_PC_Write;
  assign w_pc_plus4  = r_pc + DATA_WIDTH'(4);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (!bus.Block_PC_Write) begin
      r_pc <= w_flush_acc ? bus.Branch_Target : w_pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ifid_instr <= '0;
      r_ifid_pc4   <= '0;
      r_ifid_valid <= 1'b0;
    end else if (!bus.Block_IF_ID_Write) begin
      if (w_flush_acc) begin
        r_ifid_instr <= '0;
        r_ifid_pc4   <= '0;
        r_ifid_valid <= 1'b0;
      end else begin
        r_ifid_instr <= bus.Instruction;
        r_ifid_pc4   <= w_pc_plus4;
        r_ifid_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (bus.Stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      if (w_flush_acc && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
    end
  end

  assign bus.PC                = r_pc;
  assign bus.IF_ID_Instruction = r_ifid_instr;
  assign bus.IF_ID_PC_Plus4    = r_ifid_pc4;
  assign bus.IF_ID_Valid       = r_ifid_valid;
  assign bus.Stall_Count       = r_stall_cnt;
  assign bus.Flush_Count       = r_flush_cnt;
  assign bus.ID_EX_Control     =
    (bus.Stall || !r_ifid_valid) ? '0 : bus.ID_Control;

endmodule

// File: doc/fetch_stage_controller.md
# fetch_stage_controller

Fetch-side consumer of the hazard unit's control outputs: owns the program counter and the IF/ID pipeline register, and applies stall, PC-hold, IF/ID-hold and branch-flush requests cycle by cycle. It also inserts control bubbles into the ID/EX control bundle and keeps saturating stall/flush event counters for performance debug. It sits between instruction memory and the decode stage, driven by the hazard detection unit's outputs.

## Interface
- DATA_WIDTH, 32, width of PC, instruction and branch target
- CTRL_WIDTH, 9, width of the decoded ID control bundle
- RESET_PC, 32'h0040_0000, PC value loaded on reset
- CNT_WIDTH, 16, width of each event counter
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- Stall  in  1  hazard unit: zero the ID/EX control bundle this cycle
- Flush  in  1  hazard unit: branch taken in ID, discard fetched instruction, redirect PC
- Block_PC_Write  in  1  hazard unit: hold PC
- Block_IF_ID_Write  in  1  hazard unit: hold IF/ID register
- Branch_Target  in  DATA_WIDTH  redirect address, valid when Flush=1
- Instruction  in  DATA_WIDTH  instruction memory read data for current PC (combinational read)
- ID_Control  in  CTRL_WIDTH  control bundle from main decoder
- PC  out  DATA_WIDTH  current program counter (registered)
- IF_ID_Instruction  out  DATA_WIDTH  registered instruction for decode
- IF_ID_PC_Plus4  out  DATA_WIDTH  registered PC+4 of that instruction
- IF_ID_Valid  out  1  IF/ID holds a real instruction (0 = bubble)
- ID_EX_Control  out  CTRL_WIDTH  control bundle to ID/EX, bubbled when required
- Stall_Count  out  CNT_WIDTH  cycles with Stall=1, saturating
- Flush_Count  out  CNT_WIDTH  accepted flushes, saturating

## Operation
- Reset values (all registered outputs): PC=RESET_PC, IF_ID_Instruction=0, IF_ID_PC_Plus4=0, IF_ID_Valid=0, Stall_Count=0, Flush_Count=0. Reset overrides every other input, including mid-stall or mid-flush.
- Flush is "accepted" when Flush=1 and Block_PC_Write=0. Hold has priority: with Block_PC_Write=1, Flush is ignored that cycle; the branch re-evaluates after the stall clears.
- PC next-state priority: reset -> RESET_PC; Block_PC_Write=1 -> hold; accepted Flush -> Branch_Target; else PC+4, modulo 2^DATA_WIDTH (wraps at all-ones+4).
- IF/ID next-state priority: reset -> zeros/invalid; Block_IF_ID_Write=1 -> hold all fields including valid; accepted Flush -> Instruction=0 (nop), PC_Plus4=0, Valid=0; else load Instruction, PC+4, Valid=1.
- If Block_IF_ID_Write=0 while Block_PC_Write=1 (inconsistent hazard outputs), each hold is honored independently; Flush is still not accepted.
- ID_EX_Control = all zeros when Stall=1 or IF_ID_Valid=0; else ID_Control. Purely combinational.
- Stall_Count increments on each non-reset cycle with Stall=1; Flush_Count increments on each accepted Flush. Both stop at 2^CNT_WIDTH-1 (no wrap).

## Timing
- PC and IF/ID update one cycle after inputs are sampled; ID_EX_Control has zero-cycle latency.
- Load-use stall: one hold cycle per asserted Block_* cycle; instruction in IF/ID re-presented to decode unchanged next cycle.
- Taken branch: exactly one bubble (IF_ID_Valid=0 for one cycle); target instruction in IF/ID two edges after Flush sampled.
- No handshake; hazard inputs are level signals sampled every rising edge.

## Test plan
- Reset then 3 free-run cycles, Instruction=32'h2008_0005 -> PC 0x00400000, 0x00400004, 0x00400008, 0x0040000C; IF_ID_Valid=1 from second edge, IF_ID_PC_Plus4=0x00400004.
- Load-use: Stall=Block_PC_Write=Block_IF_ID_Write=1 for 1 cycle at PC=0x00400008 -> PC holds one cycle, IF/ID unchanged, ID_EX_Control=0 that cycle, Stall_Count=1.
- Flush=1, Branch_Target=0x00400040 -> next PC=0x00400040, IF_ID_Instruction=0, IF_ID_Valid=0, ID_EX_Control=0 next cycle, Flush_Count=1.
- Flush and Block_PC_Write both 1 -> PC holds, Flush_Count unchanged; next cycle Flush alone -> PC=Branch_Target.
- PC=32'hFFFF_FFFC free-run -> PC=0; Stall held 70000 cycles with CNT_WIDTH=16 -> Stall_Count=16'hFFFF.
- reset asserted mid-stall with Flush=1 -> all registered outputs at reset values after that edge.
